// File: rtl/fma_16_if.sv
// Operand, control and result bundle for the binary16 fused multiply-add unit.
// The unit is the slave; the caller drives operands as the master.
interface fma_16_if;
   logic [15:0] x;
   logic [15:0] y;
   logic [15:0] z;
   logic        mul;
   logic        add;
   logic        negp;
   logic        negz;
   logic [1:0]  roundmode;
   logic [15:0] result;
   logic [3:0]  flags;
   logic [3:0]  flags_acc;

   modport master (
      output x, y, z, mul, add, negp, negz, roundmode,
      input  result, flags, flags_acc
   );

   modport slave (
      input  x, y, z, mul, add, negp, negz, roundmode,
      output result, flags, flags_acc
   );
endinterface

// File: rtl/fma_16.sv
// Binary16 fused multiply-add: +/-(x*y) +/- z with one final rounding.
// The arithmetic is combinational; only the sticky exception flags are clocked.
module fma_16 (
   input logic     clk,
   input logic     reset,
   fma_16_if.slave bus
);

   // Every finite operand is an integer multiple of 2^-24, so products are
   // multiples of 2^-48; this many bits holds any finite sum exactly.
   localparam int W = 82;

   typedef enum logic [1:0] {
      RZ  = 2'b00,
      RNE = 2'b01,
      RM  = 2'b10,
      RP  = 2'b11
   } roundMode_t;

   function automatic logic isNan(input logic [14:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
   endfunction

   function automatic logic isSnan(input logic [14:0] v);
      return isNan(v) && !v[9];
   endfunction

   function automatic logic isInf(input logic [14:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] == 10'd0);
   endfunction

   function automatic logic isZero(input logic [14:0] v);
      return v == 15'd0;
   endfunction

   function automatic logic [10:0] sigOf(input logic [14:0] v);
      return {(v[14:10] != 5'd0), v[9:0]};
   endfunction

   function automatic logic [5:0] expOf(input logic [4:0] e);
      return (e == 5'd0) ? 6'd1 : {1'b0, e};
   endfunction

   roundMode_t   mode;
   logic [15:0]  opX;
   logic [15:0]  opY;
   logic [15:0]  opZ;
   logic         signP;
   logic         signA;
   logic         anyNan;
   logic         anySnan;
   logic         invalidMul;
   logic         prodInf;
   logic         addInf;
   logic         invalidAdd;
   logic         invalid;
   logic [21:0]  prodSig;
   logic [5:0]   prodShift;
   logic [5:0]   addShift;
   logic [W-1:0] prodMag;
   logic [W-1:0] addMag;
   logic [W-1:0] sumMag;
   logic [W-1:0] normMag;
   logic         sumSign;
   logic         zeroSign;
   logic [6:0]   lead;
   logic [6:0]   normPos;
   logic [6:0]   normShift;
   logic [6:0]   expField;
   logic         guardBit;
   logic         stickyBit;
   logic         inexactBits;
   logic         roundInc;
   logic         overflowToInf;
   logic [16:0]  packedRes;
   logic [16:0]  rounded;
   logic         overflow;
   logic         underflow;
   logic [15:0]  resultVal;
   logic [3:0]   flagsVal;
   logic [3:0]   flagsAcc_q;
   logic [3:0]   flagsAcc_d;

   assign mode  = roundMode_t'(bus.roundmode);
   assign opX   = bus.x;
   assign opY   = bus.mul ? bus.y : 16'h3C00;
   assign opZ   = bus.add ? bus.z : 16'h0000;
   assign signP = opX[15] ^ opY[15] ^ bus.negp;
   assign signA = opZ[15] ^ bus.negz;

   assign anyNan     = isNan(opX[14:0]) | isNan(opY[14:0]) | isNan(opZ[14:0]);
   assign anySnan    = isSnan(opX[14:0]) | isSnan(opY[14:0]) | isSnan(opZ[14:0]);
   assign invalidMul = (isInf(opX[14:0]) & isZero(opY[14:0]))
                     | (isZero(opX[14:0]) & isInf(opY[14:0]));
   assign prodInf    = (isInf(opX[14:0]) | isInf(opY[14:0])) & !invalidMul
                     & !isNan(opX[14:0]) & !isNan(opY[14:0]);
   assign addInf     = isInf(opZ[14:0]);
   assign invalidAdd = prodInf & addInf & (signP != signA);
   assign invalid    = anySnan | invalidMul | invalidAdd;

   // Both terms are placed on a common grid with lsb = 2^-48, so alignment
   // is a plain left shift and nothing below the rounding point is ever lost.
   assign prodSig   = {11'd0, sigOf(opX[14:0])} * {11'd0, sigOf(opY[14:0])};
   assign prodShift = expOf(opX[14:10]) + expOf(opY[14:10]) - 6'd2;
   assign addShift  = expOf(opZ[14:10]) + 6'd23;
   assign prodMag   = {60'd0, prodSig} << prodShift;
   assign addMag    = {71'd0, sigOf(opZ[14:0])} << addShift;

   // Sign-magnitude add: the larger magnitude decides the sign on subtraction.
   always_comb begin
      sumMag  = '0;
      sumSign = signP;
      if (signP == signA) begin
         sumMag = prodMag + addMag;
      end else if (prodMag >= addMag) begin
         sumMag = prodMag - addMag;
      end else begin
         sumMag  = addMag - prodMag;
         sumSign = signA;
      end
   end

   assign zeroSign = (signP == signA) ? signP : (mode == RM);

   always_comb begin
      lead = '0;
      for (int i = 0; i < W; i++) begin
         if (sumMag[i]) begin
            lead = 7'(i);
         end
      end
   end

   // Bit 34 of the grid is 2^-14; below it the result is subnormal and the
   // significand stays pinned at that exponent instead of normalising further.
   assign normPos   = (lead < 7'd34) ? 7'd34 : lead;
   assign normShift = 7'd81 - normPos;
   assign normMag   = sumMag << normShift;
   assign expField  = normMag[W-1] ? (lead - 7'd33) : 7'd0;
   assign guardBit  = normMag[70];
   assign stickyBit = |normMag[69:0];
   assign inexactBits = guardBit | stickyBit;

   always_comb begin
      case (mode)
         RZ:      roundInc = 1'b0;
         RNE:     roundInc = guardBit & (stickyBit | normMag[71]);
         RM:      roundInc = sumSign & inexactBits;
         RP:      roundInc = !sumSign & inexactBits;
         default: roundInc = 1'b0;
      endcase
   end

   // Incrementing the packed exponent/fraction lets a fraction carry roll
   // into the exponent, including the subnormal-to-normal step.
   assign packedRes = {expField, normMag[80:71]};
   assign rounded   = packedRes + {16'd0, roundInc};
   assign overflow  = rounded >= 17'h07C00;
   assign underflow = !overflow && (rounded < 17'h00400) && inexactBits;

   always_comb begin
      case (mode)
         RZ:      overflowToInf = 1'b0;
         RNE:     overflowToInf = 1'b1;
         RM:      overflowToInf = sumSign;
         RP:      overflowToInf = !sumSign;
         default: overflowToInf = 1'b1;
      endcase
   end

   // Special operands take priority over the finite datapath result.
   always_comb begin
      resultVal = 16'h0000;
      flagsVal  = 4'b0000;
      if (anyNan || invalid) begin
         resultVal = 16'h7E00;
         flagsVal  = {invalid, 3'b000};
      end else if (prodInf) begin
         resultVal = {signP, 15'h7C00};
      end else if (addInf) begin
         resultVal = {signA, 15'h7C00};
      end else if (sumMag == '0) begin
         resultVal = {zeroSign, 15'h0000};
      end else if (overflow) begin
         resultVal = {sumSign, overflowToInf ? 15'h7C00 : 15'h7BFF};
         flagsVal  = 4'b0101;
      end else begin
         resultVal = {sumSign, rounded[14:0]};
         flagsVal  = {2'b00, underflow, inexactBits};
      end
   end

   assign flagsAcc_d = flagsAcc_q | flagsVal;

   // Sticky status: ORs in the current flags every cycle until reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flagsAcc_q <= 4'b0000;
      end else begin
         flagsAcc_q <= flagsAcc_d;
      end
   end

   assign bus.result    = resultVal;
   assign bus.flags     = flagsVal;
   assign bus.flags_acc = flagsAcc_q;

endmodule

// File: tb/tb_fma_16.sv
// Self-checking bench for fma_16: a directed vector table, sticky-flag
// sequences around reset, and random operands against a value-level model.
module tb_fma_16;

   typedef logic [159:0] big_t;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic        mul;
      logic        add;
      logic        negp;
      logic        negz;
      logic [1:0]  rm;
      logic [15:0] expRes;
      logic [3:0]  expFlags;
   } vec_t;

   localparam int NVEC  = 23;
   localparam int NRAND = 400;

   logic       clk;
   logic       reset;
   int         errors;
   int         checks;
   logic [3:0] accExp;
   vec_t       vecs [NVEC];

   fma_16_if bus ();

   fma_16 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Exact magnitude of a binary16 pattern in units of 2^-48; 0x7C00 maps to 2^16.
   function automatic big_t halfMag(input logic [14:0] p);
      big_t sig;
      int   e;
      e   = (p[14:10] == 5'd0) ? 1 : int'(p[14:10]);
      sig = big_t'({(p[14:10] != 5'd0), p[9:0]});
      return sig << (e + 23);
   endfunction

   function automatic logic hIsNan(input logic [15:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
   endfunction

   function automatic logic hIsInf(input logic [15:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] == 10'd0);
   endfunction

   function automatic logic hIsZero(input logic [15:0] v);
      return v[14:0] == 15'd0;
   endfunction

   // Reference: exact value of P+A, then pick the neighbouring representable
   // values by binary search over the monotone positive bit patterns.
   task automatic refModel(input logic [15:0] x, input logic [15:0] yIn, input logic [15:0] zIn,
                           input logic mul, input logic add, input logic negp, input logic negz,
                           input logic [1:0] rm, output logic [15:0] res, output logic [3:0] fl);
      logic [15:0] y;
      logic [15:0] z;
      logic        ps, as, s, up, nanIn, inv, pInf, away;
      big_t        pm, am, a, lower, upper;
      int          lo, hi, mid, p, r;
      y     = mul ? yIn : 16'h3C00;
      z     = add ? zIn : 16'h0000;
      ps    = x[15] ^ y[15] ^ negp;
      as    = z[15] ^ negz;
      nanIn = hIsNan(x) || hIsNan(y) || hIsNan(z);
      inv   = (hIsNan(x) && !x[9]) || (hIsNan(y) && !y[9]) || (hIsNan(z) && !z[9])
           || (hIsInf(x) && hIsZero(y)) || (hIsZero(x) && hIsInf(y));
      pInf  = !nanIn && !inv && (hIsInf(x) || hIsInf(y));
      if (pInf && hIsInf(z) && (ps != as)) inv = 1'b1;
      away  = (rm == 2'b01) || ((rm == 2'b10) && ps) || ((rm == 2'b11) && !ps);
      res   = 16'h0000;
      fl    = 4'b0000;
      if (nanIn || inv) begin
         res = 16'h7E00;
         fl  = {inv, 3'b000};
      end else if (pInf) begin
         res = {ps, 15'h7C00};
      end else if (hIsInf(z)) begin
         res = {as, 15'h7C00};
      end else begin
         pm = (halfMag(x[14:0]) * halfMag(y[14:0])) >> 48;
         am = halfMag(z[14:0]);
         if (ps == as) begin
            a = pm + am;
            s = ps;
         end else if (pm >= am) begin
            a = pm - am;
            s = ps;
         end else begin
            a = am - pm;
            s = as;
         end
         if (a == '0) begin
            res = {((ps == as) ? ps : (rm == 2'b10)), 15'h0000};
         end else begin
            away = (rm == 2'b01) || ((rm == 2'b10) && s) || ((rm == 2'b11) && !s);
            if (halfMag(15'h7C00) <= a) begin
               p = 32'h7C00;
            end else begin
               lo = 0;
               hi = 32'h7C00;
               while (hi - lo > 1) begin
                  mid = (lo + hi) / 2;
                  if (halfMag(15'(mid)) <= a) lo = mid;
                  else hi = mid;
               end
               p = lo;
            end
            if (p == 32'h7C00) begin
               res = {s, away ? 15'h7C00 : 15'h7BFF};
               fl  = 4'b0101;
            end else begin
               lower = halfMag(15'(p));
               upper = halfMag(15'(p + 1));
               if (lower == a) begin
                  res = {s, 15'(p)};
               end else begin
                  case (rm)
                     2'b00:   up = 1'b0;
                     2'b01:   up = ((a << 1) > (lower + upper))
                                || (((a << 1) == (lower + upper)) && ((p % 2) == 1));
                     2'b10:   up = s;
                     default: up = !s;
                  endcase
                  r   = up ? p + 1 : p;
                  res = {s, 15'(r)};
                  if (r == 32'h7C00) fl = 4'b0101;
                  else fl = {2'b00, (r < 32'h0400), 1'b1};
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                input logic mul, input logic add, input logic negp,
                                input logic negz, input logic [1:0] rm);
      @(negedge clk);
      bus.x         = x;
      bus.y         = y;
      bus.z         = z;
      bus.mul       = mul;
      bus.add       = add;
      bus.negp      = negp;
      bus.negz      = negz;
      bus.roundmode = rm;
   endtask

   task automatic applyIdle();
      applyStimulus(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] randHalf(input logic narrow);
      logic [15:0] v;
      v = 16'($urandom);
      if (narrow) v[14:10] = 5'($urandom_range(8, 22));
      return v;
   endfunction

   initial begin
      logic [15:0] rx, ry, rz, mRes;
      logic [3:0]  mFl;
      logic        rMul, rAdd, rNegp, rNegz, narrow;
      logic [1:0]  rRm;

      errors = 0;
      checks = 0;
      accExp = 4'b0000;

      //             x        y        z        mul   add   negp  negz  rm     result   flags
      vecs[0]  = '{16'h3C00, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h4000, 4'b0000};
      vecs[1]  = '{16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 16'hBC00, 4'b0000};
      vecs[2]  = '{16'h3C00, 16'h0000, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h4000, 4'b0000};
      vecs[3]  = '{16'h3C00, 16'h0000, 16'hBC00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0000, 4'b0000};
      vecs[4]  = '{16'h3C00, 16'h0000, 16'hBC00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 16'h8000, 4'b0000};
      vecs[5]  = '{16'h3C00, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h3C00, 4'b0001};
      vecs[6]  = '{16'h3C00, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'h3C01, 4'b0001};
      vecs[7]  = '{16'h3C00, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h3C00, 4'b0001};
      vecs[8]  = '{16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7C00, 4'b0101};
      vecs[9]  = '{16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h7BFF, 4'b0101};
      vecs[10] = '{16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 16'hFBFF, 4'b0101};
      vecs[11] = '{16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 16'h7BFF, 4'b0101};
      vecs[12] = '{16'h7C00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7E00, 4'b1000};
      vecs[13] = '{16'h7E00, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7E00, 4'b0000};
      vecs[14] = '{16'h7C01, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7E00, 4'b1000};
      vecs[15] = '{16'h7C00, 16'h3C00, 16'h7C00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'h7E00, 4'b1000};
      vecs[16] = '{16'h7C00, 16'h3C00, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h7C00, 4'b0000};
      vecs[17] = '{16'h0400, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0200, 4'b0000};
      vecs[18] = '{16'h0401, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0200, 4'b0011};
      vecs[19] = '{16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0000, 4'b0011};
      vecs[20] = '{16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0001, 4'b0011};
      vecs[21] = '{16'h8000, 16'h3C00, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h8000, 4'b0000};
      vecs[22] = '{16'h3C01, 16'h3C01, 16'hBC00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 16'h1801, 4'b0001};

      reset         = 1'b0;
      bus.x         = 16'h0000;
      bus.y         = 16'h0000;
      bus.z         = 16'h0000;
      bus.mul       = 1'b0;
      bus.add       = 1'b0;
      bus.negp      = 1'b0;
      bus.negz      = 1'b0;
      bus.roundmode = 2'b00;
      #12;
      checkOutput("acc_reset_state", {12'd0, bus.flags_acc}, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      // Directed vectors: combinational result and flags for each record.
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].mul, vecs[i].add,
                       vecs[i].negp, vecs[i].negz, vecs[i].rm);
         #2;
         checkOutput($sformatf("vec%0d_result", i), bus.result, vecs[i].expRes);
         checkOutput($sformatf("vec%0d_flags", i), {12'd0, bus.flags}, {12'd0, vecs[i].expFlags});
      end

      // Sticky register: clear, accumulate, asynchronous clear, resume.
      applyIdle();
      reset = 1'b0;
      #1;
      checkOutput("acc_clear", {12'd0, bus.flags_acc}, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(16'h0401, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      #2;
      checkOutput("acc_before_edge", {12'd0, bus.flags_acc}, 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("acc_after_edge", {12'd0, bus.flags_acc}, 16'h0003);
      applyIdle();
      @(posedge clk);
      #1;
      checkOutput("acc_hold", {12'd0, bus.flags_acc}, 16'h0003);
      applyStimulus(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      @(posedge clk);
      #1;
      checkOutput("acc_or", {12'd0, bus.flags_acc}, 16'h0007);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("acc_async_clear", {12'd0, bus.flags_acc}, 16'h0000);
      checkOutput("result_in_reset", bus.result, 16'h7C00);
      @(posedge clk);
      #1;
      checkOutput("acc_held_in_reset", {12'd0, bus.flags_acc}, 16'h0000);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("acc_after_release", {12'd0, bus.flags_acc}, 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("acc_resume", {12'd0, bus.flags_acc}, 16'h0005);

      // Random operands against the reference model, tracking the sticky OR too.
      applyIdle();
      reset = 1'b0;
      #1;
      reset  = 1'b1;
      accExp = 4'b0000;
      for (int i = 0; i < NRAND; i++) begin
         narrow = 1'($urandom_range(0, 1));
         rx     = randHalf(narrow);
         ry     = randHalf(narrow);
         rz     = randHalf(narrow);
         rMul   = ($urandom_range(0, 3) != 0);
         rAdd   = ($urandom_range(0, 3) != 0);
         rNegp  = 1'($urandom_range(0, 1));
         rNegz  = 1'($urandom_range(0, 1));
         rRm    = 2'($urandom_range(0, 3));
         applyStimulus(rx, ry, rz, rMul, rAdd, rNegp, rNegz, rRm);
         refModel(rx, ry, rz, rMul, rAdd, rNegp, rNegz, rRm, mRes, mFl);
         #2;
         checkOutput($sformatf("rand%0d_result", i), bus.result, mRes);
         checkOutput($sformatf("rand%0d_flags", i), {12'd0, bus.flags}, {12'd0, mFl});
         checkOutput($sformatf("rand%0d_acc", i), {12'd0, bus.flags_acc}, {12'd0, accExp});
         accExp = accExp | mFl;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
